shift_deserializer: RTL and testbench
=====================================

# shift_deserializer

- Receive side of the ALU's serial operand path: collects bits from a serial line into a WIDTH-bit word and presents it on a valid/ready output.
- `lsb_first` selects shift direction per frame, mirroring the left/right selection of the four-bit shift circuit.
- Frame register and output holding register are separate, so a new frame can be received while the previous word waits to be taken.
- Optional even-parity bit per frame.

## Interface
Parameters:
- WIDTH, 4, data bits per frame (≥2)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 forces reset state
- serial_in  in  1  serial data bit
- serial_valid  in  1  serial_in is a bit this cycle
- frame_start  in  1  with serial_valid, marks bit 0 of a new frame
- lsb_first  in  1  1: first bit is data[0]; 0: first bit is data[WIDTH-1]; sampled with bit 0
- out_ready  in  1  consumer accepts data_out this cycle
- data_out  out  WIDTH  received word
- out_valid  out  1  data_out/parity_err hold an untaken word
- parity_err  out  1  parity mismatch for word on data_out (qualified by out_valid)
- overrun  out  1  one-cycle pulse: completed frame dropped
- busy  out  1  frame in progress (state ≠ IDLE)

## Operation
- States: IDLE, SHIFT, PARITY (macro only).
- IDLE:
  - serial_valid & frame_start → capture bit 0 and latch lsb_first; count=1; → SHIFT.
  - serial_valid without frame_start is ignored.
- SHIFT: on each serial_valid bit:
  - lsb_first=1: sr ← {bit, sr[WIDTH-1:1]}.
  - lsb_first=0: sr ← {sr[WIDTH-2:0], bit}.
  - count increments.
  - When the WIDTH-th bit is accepted: go to PARITY (macro) or complete the frame and return to IDLE.
- PARITY: next serial_valid bit is the parity bit; complete the frame → IDLE.
- Completion:
  - If out_valid=0, or out_valid=1 and out_ready=1 in the same cycle: load data_out (and parity_err); out_valid=1.
  - Otherwise discard the frame, leave the holding register unchanged, pulse overrun.
- Handshake: out_valid & out_ready with no simultaneous completion → out_valid=0 next cycle. data_out is stable while out_valid=1 and out_ready=0.
- Mid-frame frame_start (serial_valid=1, state SHIFT/PARITY): abort the current frame with no overrun or output change; the bit becomes bit 0 of a new frame, count=1, lsb_first re-latched.
- serial_valid=0 cycles inside a frame: no state change, no timeout.
- Count wraps to 0 on completion; it never exceeds WIDTH.

## Timing
- Reset values (reset=0, immediate): data_out=0, out_valid=0, parity_err=0, overrun=0, busy=0, state=IDLE, count=0, shift register=0.
- Latency: out_valid rises on the clock edge that samples the last frame bit (data bit WIDTH, or parity bit); visible the following cycle.
- overrun asserts on that same edge for exactly one cycle.
- busy is high from the edge after bit 0 until the edge of completion.
- Back-to-back frames need no idle gap: the bit after completion may carry frame_start.
- Reset deasserting mid-frame: the partial frame is lost; the block starts in IDLE.

## Configuration
- SHIFT_DESERIALIZER_PARITY_EN defined:
  - Frame is WIDTH data bits plus one even-parity bit.
  - parity_err = XOR(data bits, parity bit), registered with data_out.
  - Overrun and abort rules also apply to the PARITY state.
- Not defined:
  - Frame is WIDTH bits; PARITY state absent.
  - parity_err port present but tied to 0.

## Test plan
- Reset, then LSB-first bits 0,1,0,1 with frame_start on the first bit, out_ready=1 → data_out=4'b1010, out_valid for one cycle, busy low afterward.
- MSB-first bits 1,1,0,0 with out_ready=0 → data_out=4'b1100 held stable; then out_ready=1 → out_valid falls the next cycle.
- With word 4'b1100 untaken, receive a second frame 0,0,1,1 (LSB-first) → overrun pulses once, data_out remains 4'b1100. Repeat with out_ready=1 on the completion cycle → data_out=4'b1100 replaced, no overrun.
- Two bits of a frame, then frame_start with bits 1,0,1,0 MSB-first → data_out=4'b1010, no overrun, aborted bits have no effect. Assert reset mid-frame → all outputs 0 immediately.
- Macro defined: data 4'b0110 with parity bit 0 → parity_err=0; same data with parity bit 1 → parity_err=1. Macro undefined: parity_err stays 0 and the frame completes after 4 bits.

Source files
------------

// File: rtl/shift_deserializer_if.sv
// Serial-in / word-out bus of shift_deserializer.
// slave: the deserializer side; master: the side that feeds bits and takes words.
interface shift_deserializer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             serial_in;
  logic             serial_valid;
  logic             frame_start;
  logic             lsb_first;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             parity_err;
  logic             overrun;
  logic             busy;

  modport slave (
    input  serial_in, serial_valid, frame_start, lsb_first, out_ready,
    output data_out, out_valid, parity_err, overrun, busy
  );

  modport master (
    output serial_in, serial_valid, frame_start, lsb_first, out_ready,
    input  data_out, out_valid, parity_err, overrun, busy
  );
endinterface

// File: rtl/shift_deserializer.sv
// shift_deserializer: collects serial bits into a WIDTH-bit word and presents
// it through a valid/ready holding register. The frame shift register and the
// holding register are separate, so a new frame can arrive while the previous
// word waits to be taken.
// Optional feature: define SHIFT_DESERIALIZER_PARITY_EN to append one
// even-parity bit to each frame and report mismatches on parity_err.
module shift_deserializer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  shift_deserializer_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

`ifdef SHIFT_DESERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             lsb_q, lsb_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] sr_shift;
  logic [WIDTH-1:0] sr_start;
  logic [WIDTH-1:0] word;
  logic             complete;
  logic             restart;

`ifdef SHIFT_DESERIALIZER_PARITY_EN
  logic perr_q, perr_d;
  logic word_perr;
`endif

  // Shift datapath: next register value for a continuing bit and for bit 0
  always_comb begin
    if (lsb_q) sr_shift = {bus.serial_in, sr_q[WIDTH-1:1]};
    else       sr_shift = {sr_q[WIDTH-2:0], bus.serial_in};
    if (bus.lsb_first) sr_start = {bus.serial_in, {(WIDTH-1){1'b0}}};
    else               sr_start = {{(WIDTH-1){1'b0}}, bus.serial_in};
  end

  // Next-state, frame assembly and holding-register handshake
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    sr_d      = sr_q;
    lsb_d     = lsb_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    complete  = 1'b0;
    word      = sr_shift;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
    perr_d    = perr_q;
    word_perr = 1'b0;
`endif
    restart   = bus.serial_valid && bus.frame_start;

    if (valid_q && bus.out_ready) valid_d = 1'b0;

    // frame_start wins in every state: mid-frame it silently aborts the
    // partial frame, so no completion/overrun can occur on that bit
    if (restart) begin
      sr_d    = sr_start;
      lsb_d   = bus.lsb_first;
      count_d = CNT_W'(1);
      state_d = SHIFT;
    end else if (bus.serial_valid) begin
      case (state_q)
        SHIFT: begin
          sr_d = sr_shift;
          if (count_q == LAST_IDX) begin
`ifdef SHIFT_DESERIALIZER_PARITY_EN
            count_d = CNT_W'(WIDTH);
            state_d = PARITY;
`else
            complete = 1'b1;
            word     = sr_shift;
            count_d  = '0;
            state_d  = IDLE;
`endif
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
`ifdef SHIFT_DESERIALIZER_PARITY_EN
        PARITY: begin
          complete  = 1'b1;
          word      = sr_q;
          word_perr = (^sr_q) ^ bus.serial_in;
          count_d   = '0;
          state_d   = IDLE;
        end
`endif
        default: ;
      endcase
    end

    if (complete) begin
      if (!valid_q || bus.out_ready) begin
        data_d  = word;
        valid_d = 1'b1;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
        perr_d  = word_perr;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      sr_q      <= '0;
      lsb_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      sr_q      <= sr_d;
      lsb_q     <= lsb_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef SHIFT_DESERIALIZER_PARITY_EN
  // Parity flag travels with the held word
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) perr_q <= 1'b0;
    else        perr_q <= perr_d;
  end
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.data_out  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_deserializer.sv
// Testbench for shift_deserializer: directed frames followed by random
// traffic, each cycle compared against a bit-list reference model.
module tb_shift_deserializer;

  localparam int unsigned WIDTH = 4;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
  localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
  localparam int unsigned FRAME_LEN = WIDTH;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  shift_deserializer_if #(.WIDTH(WIDTH)) bus ();

  shift_deserializer #(.WIDTH(WIDTH)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  // Reference model: a frame is the ordered list of received bits
  int               m_bits[$];
  logic             m_busy = 1'b0;
  logic             m_lsb = 1'b0;
  logic [WIDTH-1:0] m_data = '0;
  logic             m_valid = 1'b0;
  logic             m_perr = 1'b0;
  logic             m_ovr = 1'b0;

  task automatic model_reset();
    m_bits.delete();
    m_busy = 1'b0; m_lsb = 1'b0; m_data = '0;
    m_valid = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_edge(input logic sv, input logic fs, input logic b,
                            input logic lsb, input logic rdy);
    logic             loaded;
    logic [WIDTH-1:0] w;
    logic             par;
    loaded = 1'b0;
    m_ovr  = 1'b0;
    if (sv) begin
      if (fs) begin
        m_bits.delete();
        m_bits.push_back(int'(b));
        m_lsb  = lsb;
        m_busy = 1'b1;
      end else if (m_busy) begin
        m_bits.push_back(int'(b));
        if (m_bits.size() == FRAME_LEN) begin
          w   = '0;
          par = 1'b0;
          for (int i = 0; i < WIDTH; i++) begin
            if (m_lsb) w[i] = m_bits[i][0];
            else       w[WIDTH-1-i] = m_bits[i][0];
            par ^= m_bits[i][0];
          end
`ifdef SHIFT_DESERIALIZER_PARITY_EN
          par ^= m_bits[WIDTH][0];
`else
          par = 1'b0;
`endif
          if (!m_valid || rdy) begin
            m_data  = w;
            m_perr  = par;
            m_valid = 1'b1;
            loaded  = 1'b1;
          end else begin
            m_ovr = 1'b1;
          end
          m_busy = 1'b0;
          m_bits.delete();
        end
      end
    end
    if (m_valid && rdy && !loaded) m_valid = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("data_out",   32'(bus.data_out),   32'(m_data));
    check("out_valid",  32'(bus.out_valid),  32'(m_valid));
    check("parity_err", 32'(bus.parity_err), 32'(m_perr));
    check("overrun",    32'(bus.overrun),    32'(m_ovr));
    check("busy",       32'(bus.busy),       32'(m_busy));
  endtask

  // One clock: drive at negedge, model the edge, check at the next negedge
  task automatic step(input logic sv, input logic fs, input logic b,
                      input logic lsb, input logic rdy);
    bus.serial_valid = sv;
    bus.frame_start  = fs;
    bus.serial_in    = b;
    bus.lsb_first    = lsb;
    bus.out_ready    = rdy;
    @(posedge clk);
    model_edge(sv, fs, b, lsb, rdy);
    @(negedge clk);
    check_all();
  endtask

  // seq[i] is the i-th bit on the line; pbit is the parity bit if enabled
  task automatic send_frame(input logic [WIDTH-1:0] seq, input logic lsb,
                            input logic rdy_body, input logic rdy_last,
                            input logic pbit, input logic gaps);
    logic b;
    for (int i = 0; i < FRAME_LEN; i++) begin
      b = (i < WIDTH) ? seq[i] : pbit;
      if (gaps && i > 0 && $urandom_range(0, 1) == 1)
        step(1'b0, 1'b0, 1'($urandom), lsb, rdy_body);
      step(1'b1, (i == 0), b, lsb, (i == FRAME_LEN - 1) ? rdy_last : rdy_body);
    end
  endtask

  initial begin
    bus.serial_in = 1'b0; bus.serial_valid = 1'b0; bus.frame_start = 1'b0;
    bus.lsb_first = 1'b0; bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // LSB-first 0,1,0,1 taken immediately
    send_frame(4'b1010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("lsb_word", 32'(bus.data_out), 32'h0000000A);
    check("lsb_valid", 32'(bus.out_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("lsb_taken", 32'(bus.out_valid), 32'h0);

    // MSB-first 1,1,0,0 held until taken
    send_frame(4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("msb_word", 32'(bus.data_out), 32'h0000000C);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("msb_hold", 32'(bus.data_out), 32'h0000000C);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("msb_drop_valid", 32'(bus.out_valid), 32'h0);

    // Overrun with untaken 1100, then replacement with ready on completion
    send_frame(4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(4'b1100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr_pulse", 32'(bus.overrun), 32'h1);
    check("ovr_keep", 32'(bus.data_out), 32'h0000000C);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr_once", 32'(bus.overrun), 32'h0);
    send_frame(4'b1110, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("replace_word", 32'(bus.data_out), 32'h0000000E);
    check("replace_no_ovr", 32'(bus.overrun), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Abort after two bits, restart MSB-first 1,0,1,0
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    send_frame(4'b0101, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("abort_word", 32'(bus.data_out), 32'h0000000A);
    check("abort_no_ovr", 32'(bus.overrun), 32'h0);

`ifdef SHIFT_DESERIALIZER_PARITY_EN
    send_frame(4'b0110, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("par_ok", 32'(bus.parity_err), 32'h0);
    send_frame(4'b0110, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("par_bad", 32'(bus.parity_err), 32'h1);
`else
    send_frame(4'b0110, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("par_tied", 32'(bus.parity_err), 32'h0);
    check("four_bit_frame", 32'(bus.out_valid), 32'h1);
`endif

    // Reset mid-frame clears outputs immediately
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    // Random traffic
    for (int n = 0; n < 600; n++)
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 11) == 0),
           1'($urandom), 1'($urandom), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
